i2c_slave_rx_ctrl: RTL
======================

Name: i2c_slave_rx_ctrl

Overview:
Receive-side sequencer for the I2C slave. It drives the bit/byte read unit through rd_en/is_byte and consumes its status strobes. It recognises START, the address byte and data bytes, and requests ACK/NACK bits from the slave ACK driver. Received bytes go to the register/host side through a one-byte valid/ready buffer; master-read transfers are handed to the transmit path.

Parameters:
ADDR_W, 7, slave address width (7-bit addressing only; the address byte is {addr[6:0], rw}).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  controller enable
own_addr  in  7  slave address, sampled at address compare
scl_i  in  1  synchronized SCL, used only to leave START_HOLD
rd_en  out  1  read unit enable
is_byte  out  1  read unit mode; this block always drives 1
rd_ld  in  1  read unit bit strobe, one per SCL fall
rd_bit  in  1  read unit data bit (its data_o)
get_start  in  1  START seen (combinational from read unit)
get_stop  in  1  STOP seen
bus_err  in  1  START/STOP at wrong bit
rd_finish  in  1  byte complete; sticky until rd_en drops
ack_req  out  1  request ACK driver to send one ACK-slot bit
ack_val  out  1  0 = ACK, 1 = NACK; valid while ack_req=1
ack_done  in  1  one-cycle pulse: ACK bit finished (after its SCL fall)
rx_data  out  8  received byte
rx_valid  out  1  rx_data valid
rx_ready  in  1  host accepts rx_data
tx_active  out  1  master-read transfer owned by transmit path
addr_hit  out  1  one-cycle pulse on address match
stop_det  out  1  one-cycle pulse on STOP while addressed
err  out  1  one-cycle pulse: bus error or overflow NACK
busy  out  1  state not IDLE/WAIT_START

Behaviour:
- Reset: state IDLE. All outputs 0 (including rx_data), except is_byte=1. Shift register and rw latch are 0.
- States: IDLE, WAIT_START, START_HOLD, ADDR, ADDR_ACK, DATA, DATA_ACK, HANDOFF, IGNORE.
- rd_en is 1 in WAIT_START, ADDR, DATA, HANDOFF and IGNORE; 0 elsewhere. It also drops for exactly one cycle on every transition that consumes rd_finish.
- IDLE: go to WAIT_START when en=1. If en=0 in any state, go to IDLE next cycle. rx_valid/rx_data are kept until consumed.
- WAIT_START, IGNORE: get_start goes to START_HOLD. rd_ld, rd_finish and bus_err are ignored. get_stop in IGNORE goes to WAIT_START.
- START_HOLD: rd_en=0, so the post-START SCL fall is not counted. Clear the shift register. Go to ADDR on the first cycle with scl_i=0.
- ADDR/DATA: on each rd_ld, shift_reg <= {shift_reg[6:0], rd_bit} (MSB first).
- ADDR on rd_finish: compare shift_reg[7:1] with own_addr. On match, latch rw=shift_reg[0], pulse addr_hit and go to ADDR_ACK with ack_val=0. On mismatch, go to IGNORE with no ack_req.
- ADDR_ACK: hold ack_req=1, ack_val=0 until ack_done. Then go to DATA if rw=0, or HANDOFF if rw=1.
- DATA on rd_finish, buffer free: the buffer is free if rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle. Load rx_data, set rx_valid=1, go to DATA_ACK with ack_val=0.
- DATA on rd_finish, buffer full: go to DATA_ACK with ack_val=1, pulse err, drop the byte.
- DATA_ACK: hold ack_req until ack_done. After ACK go to DATA; after NACK go to IGNORE.
- HANDOFF: tx_active=1; bus_err and rd_ld are ignored.
- Priority in ADDR/DATA/HANDOFF/DATA_ACK/ADDR_ACK: get_stop > get_start > bus_err > rd_finish.
  - get_stop: pulse stop_det, go to WAIT_START.
  - get_start (repeated start): go to START_HOLD.
  - bus_err alone: pulse err, go to WAIT_START.
  - bus_err coincident with START/STOP: pulse err and still take the START/STOP transition.
  - Any of these abandons a pending ack_req, which drops next cycle.
- rx_valid clears on rx_valid && rx_ready, unless a load occurs in the same cycle.
- tx_active=1 only in HANDOFF. busy=1 in all states except IDLE and WAIT_START.

Test Plan:
- own_addr=0x50; START, byte 0xA0, 2 data bytes 0x3C/0xFF, rx_ready=1, STOP -> addr_hit pulse; ack_req/ack_val=0 three times; rx_data 0x3C then 0xFF; stop_det pulse; final state WAIT_START.
- START, byte 0xA2 (address 0x51) -> no addr_hit, no ack_req; rd_ld ignored; STOP returns to WAIT_START.
- START, 0xA1 (read) -> ACK, tx_active=1; STOP -> tx_active=0.
- Write with rx_ready=0: first byte 0x11 ACKed with rx_valid=1; second byte 0x22 -> ack_val=1, err pulse, IGNORE; rx_data stays 0x11.
- START mid-byte (bus_err and get_start together) in DATA after 3 bits -> err pulse, START_HOLD, then a fresh address byte is accepted.
- rst_n low during DATA_ACK -> immediately IDLE, ack_req=0, rx_valid=0. Separately, en=0 in DATA -> IDLE next cycle.

Source files
------------

// File: rtl/i2c_slave_rx_ctrl_if.sv
// Bus bundle between the I2C slave receive sequencer and its neighbours
// (bit/byte read unit, ACK driver, host-side receive buffer, transmit path).
interface i2c_slave_rx_ctrl_if;
    logic       en;
    logic [6:0] own_addr;
    logic       scl_i;

    logic       rd_en;
    logic       is_byte;
    logic       rd_ld;
    logic       rd_bit;
    logic       get_start;
    logic       get_stop;
    logic       bus_err;
    logic       rd_finish;

    logic       ack_req;
    logic       ack_val;
    logic       ack_done;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    logic       tx_active;
    logic       addr_hit;
    logic       stop_det;
    logic       err;
    logic       busy;

    // master: the sequencer itself; slave: everything around it
    modport master (
        input  en, own_addr, scl_i,
        input  rd_ld, rd_bit, get_start, get_stop, bus_err, rd_finish,
        input  ack_done, rx_ready,
        output rd_en, is_byte, ack_req, ack_val, rx_data, rx_valid,
        output tx_active, addr_hit, stop_det, err, busy
    );

    modport slave (
        output en, own_addr, scl_i,
        output rd_ld, rd_bit, get_start, get_stop, bus_err, rd_finish,
        output ack_done, rx_ready,
        input  rd_en, is_byte, ack_req, ack_val, rx_data, rx_valid,
        input  tx_active, addr_hit, stop_det, err, busy
    );
endinterface

// File: rtl/i2c_slave_rx_ctrl.sv
// I2C slave receive sequencer: START/address/data recognition, ACK slot
// requests, one-byte receive buffer and hand-off of master-read transfers.
//
// state        | meaning
// IDLE         | controller disabled
// WAIT_START   | enabled, waiting for START
// START_HOLD   | START seen, waiting for SCL low before counting bits
// ADDR         | shifting in the address byte
// ADDR_ACK     | ACK of own address in progress
// DATA         | shifting in a write data byte
// DATA_ACK     | ACK/NACK of a data byte in progress
// HANDOFF      | master-read transfer, transmit path owns the bus
// IGNORE       | not addressed or NACKed, waiting for START/STOP
module i2c_slave_rx_ctrl #(
    parameter int ADDR_W = 7
) (
    input logic                  clk,
    input logic                  rst_n,
    i2c_slave_rx_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WAIT_START = 4'd1,
        S_START_HOLD = 4'd2,
        S_ADDR       = 4'd3,
        S_ADDR_ACK   = 4'd4,
        S_DATA       = 4'd5,
        S_DATA_ACK   = 4'd6,
        S_HANDOFF    = 4'd7,
        S_IGNORE     = 4'd8
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       ack_val_q, ack_val_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       drop_q, drop_d;
    logic       addr_hit_q, addr_hit_d;
    logic       stop_det_q, stop_det_d;
    logic       err_q, err_d;

    logic rx_take;
    logic addressed;
    logic bus_err_seen;
    logic addr_match;

    assign rx_take      = rx_valid_q & bus.rx_ready;
    assign addressed    = (state_q == S_ADDR_ACK) || (state_q == S_DATA) ||
                          (state_q == S_DATA_ACK) || (state_q == S_HANDOFF);
    assign bus_err_seen = bus.bus_err && (state_q != S_HANDOFF);
    assign addr_match   = (shift_q[7:8-ADDR_W] == bus.own_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            ack_val_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            drop_q     <= 1'b0;
            addr_hit_q <= 1'b0;
            stop_det_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ack_val_q  <= ack_val_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            drop_q     <= drop_d;
            addr_hit_q <= addr_hit_d;
            stop_det_q <= stop_det_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ack_val_d  = ack_val_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        drop_d     = 1'b0;
        addr_hit_d = 1'b0;
        stop_det_d = 1'b0;
        err_d      = 1'b0;

        if (rx_take) begin
            rx_valid_d = 1'b0;
        end

        if (bus.rd_ld && ((state_q == S_ADDR) || (state_q == S_DATA))) begin
            shift_d = {shift_q[6:0], bus.rd_bit};
        end

        if (!bus.en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (bus.get_start) begin
                        state_d = S_START_HOLD;
                    end
                end
                S_IGNORE: begin
                    if (bus.get_stop) begin
                        state_d = S_WAIT_START;
                    end else if (bus.get_start) begin
                        state_d = S_START_HOLD;
                    end
                end
                S_START_HOLD: begin
                    shift_d = 8'h00;
                    if (!bus.scl_i) begin
                        state_d = S_ADDR;
                    end
                end
                default: begin
                    // bus conditions override any byte or ACK slot in progress
                    if (bus.get_stop) begin
                        stop_det_d = addressed;
                        err_d      = bus_err_seen;
                        state_d    = S_WAIT_START;
                    end else if (bus.get_start) begin
                        err_d   = bus_err_seen;
                        state_d = S_START_HOLD;
                    end else if (bus_err_seen) begin
                        err_d   = 1'b1;
                        state_d = S_WAIT_START;
                    end else begin
                        case (state_q)
                            S_ADDR: begin
                                if (bus.rd_finish) begin
                                    drop_d = 1'b1;
                                    if (addr_match) begin
                                        rw_d       = shift_q[0];
                                        addr_hit_d = 1'b1;
                                        ack_val_d  = 1'b0;
                                        state_d    = S_ADDR_ACK;
                                    end else begin
                                        state_d = S_IGNORE;
                                    end
                                end
                            end
                            S_ADDR_ACK: begin
                                if (bus.ack_done) begin
                                    state_d = rw_q ? S_HANDOFF : S_DATA;
                                end
                            end
                            S_DATA: begin
                                if (bus.rd_finish) begin
                                    drop_d  = 1'b1;
                                    state_d = S_DATA_ACK;
                                    if (!rx_valid_q || rx_take) begin
                                        rx_data_d  = shift_q;
                                        rx_valid_d = 1'b1;
                                        ack_val_d  = 1'b0;
                                    end else begin
                                        ack_val_d = 1'b1;
                                        err_d     = 1'b1;
                                    end
                                end
                            end
                            S_DATA_ACK: begin
                                if (bus.ack_done) begin
                                    state_d = ack_val_q ? S_IGNORE : S_DATA;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // drop_q forces one idle cycle of rd_en so the read unit releases rd_finish
    assign bus.rd_en     = ((state_q == S_WAIT_START) || (state_q == S_ADDR) ||
                            (state_q == S_DATA) || (state_q == S_HANDOFF) ||
                            (state_q == S_IGNORE)) && !drop_q;
    assign bus.is_byte   = 1'b1;
    assign bus.ack_req   = (state_q == S_ADDR_ACK) || (state_q == S_DATA_ACK);
    assign bus.ack_val   = ack_val_q && bus.ack_req;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_active = (state_q == S_HANDOFF);
    assign bus.addr_hit  = addr_hit_q;
    assign bus.stop_det  = stop_det_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_WAIT_START);

endmodule
